// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with one registered output stage.
// Optional packet mode holds the grant on a channel until its last beat.

module rr_arb_mux_lane #(
  parameter int SEL_W = 2,
  parameter int K     = 0
) (
  input  logic             valid,
  input  logic             locked,
  input  logic [SEL_W-1:0] lock_sel,
  input  logic [SEL_W-1:0] ptr,
  output logic             req_hi,
  output logic             req_lo
);
  logic elig;
  logic above;

  // While locked, only the locked channel may compete.
  assign elig   = valid & (!locked | (lock_sel == SEL_W'(K)));
  assign above  = SEL_W'(K) > ptr;
  assign req_hi = elig & above;
  assign req_lo = elig & !above;
endmodule

module rr_arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int PACKET   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);
  logic [SEL_W-1:0]    ptr;
  logic                locked;
  logic [SEL_W-1:0]    lock_sel;
  logic [CHANNELS-1:0] req_hi, req_lo;
  logic [SEL_W-1:0]    win;
  logic                found;
  logic                load;
  logic                accept;
  logic [WIDTH-1:0]    sel_data;
  logic                sel_last;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    rr_arb_mux_lane #(.SEL_W(SEL_W), .K(k)) u_lane (
      .valid    (in_valid[k]),
      .locked   (locked),
      .lock_sel (lock_sel),
      .ptr      (ptr),
      .req_hi   (req_hi[k]),
      .req_lo   (req_lo[k])
    );
  end

  // Scan channels above ptr first, then wrap to 0..ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (!found && req_hi[k]) begin
        found = 1'b1;
        win   = SEL_W'(k);
      end
    for (int k = 0; k < CHANNELS; k++)
      if (!found && req_lo[k]) begin
        found = 1'b1;
        win   = SEL_W'(k);
      end
  end

  assign load = !out_valid | out_ready;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      in_ready[k] = found & load & (win == SEL_W'(k));
      if (win == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_last = in_last[k];
      end
    end
  end

  assign accept = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= SEL_W'(CHANNELS-1);
      locked    <= 1'b0;
      lock_sel  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_sel   <= win;
      if (PACKET != 0) begin
        if (sel_last) begin
          locked <= 1'b0;
          ptr    <= win;
        end else begin
          locked   <= 1'b1;
          lock_sel <= win;
        end
      end else begin
        ptr <= win;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
